// File: rtl/axis_ram_burst_writer.sv
// ---------------------------------------------------------------------------
// axis_ram_burst_writer
//
// Streams AXI4-Stream samples into a circular DDR buffer using fixed 16-beat
// AXI3 INCR write bursts. An internal first-word-fall-through FIFO absorbs
// bus latency. Completed progress is exported as a burst index for software.
//
// Ports
//   aclk, aresetn        clock; synchronous active-low reset
//   min_addr             buffer base byte address
//   cfg_data             last burst index before wrap (buffer = cfg_data+1 bursts)
//   sts_data             index of the next burst to be written
//   sts_error            sticky flag, set on any BRESP other than OKAY
//   m_axi_aw*            AXI3 write address channel (master)
//   m_axi_w*             AXI3 write data channel (master)
//   m_axi_b*             AXI3 write response channel (bid ignored)
//   s_axis_t*            AXI4-Stream sample input; tready = FIFO not full
// ---------------------------------------------------------------------------
module axis_ram_burst_writer #(
    parameter int ADDR_WIDTH       = 16,
    parameter int AXI_ID_WIDTH     = 6,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int AXI_DATA_WIDTH   = 64,
    parameter int AXIS_TDATA_WIDTH = 64,
    parameter int FIFO_WRITE_DEPTH = 512
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic [AXI_ADDR_WIDTH-1:0]     min_addr,
    input  logic [ADDR_WIDTH-1:0]         cfg_data,
    output logic [ADDR_WIDTH-1:0]         sts_data,
    output logic                          sts_error,

    output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
    output logic [3:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic [3:0]                    m_axi_awcache,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,

    output logic [AXI_ID_WIDTH-1:0]       m_axi_wid,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,

    input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,

    input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready
);

    localparam int ADDR_SIZE   = $clog2(AXI_DATA_WIDTH / 8);
    localparam int BURST_SHIFT = 4 + ADDR_SIZE;
    localparam int PTR_W       = $clog2(FIFO_WRITE_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int STRB_W      = AXI_DATA_WIDTH / 8;

    generate
        if (AXIS_TDATA_WIDTH != AXI_DATA_WIDTH) begin : g_width_check
            $error("AXIS_TDATA_WIDTH must equal AXI_DATA_WIDTH");
        end
        if ((FIFO_WRITE_DEPTH < 32) || ((1 << PTR_W) != FIFO_WRITE_DEPTH)) begin : g_depth_check
            $error("FIFO_WRITE_DEPTH must be a power of two and at least 32");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Constant AXI fields
    // -----------------------------------------------------------------------
    assign m_axi_awid    = '0;
    assign m_axi_wid     = '0;
    assign m_axi_awlen   = 4'd15;
    assign m_axi_awsize  = 3'(ADDR_SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0110;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign m_axi_wstrb[gi] = 1'b1;
        end
    endgenerate

    // BID carries no information for a single-ID master.
    logic unused_bid;
    assign unused_bid = ^m_axi_bid;

    // -----------------------------------------------------------------------
    // FIFO: block-RAM array with registered read feeding a head register,
    // giving first-word-fall-through behaviour. fifo_cnt_reg counts every
    // stored word (RAM plus head) and is what tready and the FSM look at.
    // -----------------------------------------------------------------------
    logic [AXIS_TDATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
    logic [AXIS_TDATA_WIDTH-1:0] head_data_reg;
    logic                        head_valid_reg, head_valid_next;
    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]            mem_cnt_reg, mem_cnt_next;
    logic [CNT_W-1:0]            fifo_cnt_reg, fifo_cnt_next;
    logic                        fifo_ready_reg;
    logic                        fifo_full, fifo_push, fifo_pop, fifo_load;

    assign fifo_full     = (fifo_cnt_reg == CNT_W'(FIFO_WRITE_DEPTH));
    assign s_axis_tready = fifo_ready_reg & ~fifo_full;
    assign fifo_push     = s_axis_tvalid & s_axis_tready;
    assign fifo_pop      = m_axi_wvalid & m_axi_wready;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign fifo_load     = (mem_cnt_reg != '0) & (~head_valid_reg | fifo_pop);

    always_comb begin
        mem_cnt_next    = mem_cnt_reg + CNT_W'(fifo_push) - CNT_W'(fifo_load);
        fifo_cnt_next   = fifo_cnt_reg + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        head_valid_next = head_valid_reg;
        if (fifo_load) begin
            head_valid_next = 1'b1;
        end else if (fifo_pop) begin
            head_valid_next = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (fifo_push) begin
            mem[wr_ptr_reg] <= s_axis_tdata;
        end
        if (fifo_load) begin
            head_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            mem_cnt_reg    <= '0;
            fifo_cnt_reg   <= '0;
            head_valid_reg <= 1'b0;
            fifo_ready_reg <= 1'b0;
        end else begin
            fifo_ready_reg <= 1'b1;
            if (fifo_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_load) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            mem_cnt_reg    <= mem_cnt_next;
            fifo_cnt_reg   <= fifo_cnt_next;
            head_valid_reg <= head_valid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Burst FSM
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic                      awvalid_reg, awvalid_next;
    logic                      aw_done_reg, aw_done_next;
    logic [4:0]                beat_cnt_reg, beat_cnt_next;
    logic [ADDR_WIDTH-1:0]     idx_reg, idx_next;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic                      error_reg, error_next;
    logic                      aw_hs, w_hs;

    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_awaddr  = awaddr_reg;
    // W may run ahead of the AW handshake; only the FIFO gates it.
    assign m_axi_wvalid  = (state_reg == ST_BURST) & head_valid_reg & (beat_cnt_reg < 5'd16);
    assign m_axi_wdata   = head_data_reg;
    assign m_axi_wlast   = (beat_cnt_reg == 5'd15);
    assign m_axi_bready  = (state_reg == ST_RESP);
    assign sts_data      = idx_reg;
    assign sts_error     = error_reg;

    assign aw_hs = awvalid_reg & m_axi_awready;
    assign w_hs  = m_axi_wvalid & m_axi_wready;

    always_comb begin
        state_next    = state_reg;
        awvalid_next  = awvalid_reg;
        aw_done_next  = aw_done_reg;
        beat_cnt_next = beat_cnt_reg;
        idx_next      = idx_reg;
        awaddr_next   = awaddr_reg;
        error_next    = error_reg;
        case (state_reg)
            ST_IDLE: begin
                if (fifo_cnt_reg >= CNT_W'(16)) begin
                    state_next    = ST_BURST;
                    awvalid_next  = 1'b1;
                    aw_done_next  = 1'b0;
                    beat_cnt_next = '0;
                    // Address arithmetic wraps naturally at 2^AXI_ADDR_WIDTH.
                    awaddr_next   = min_addr + (AXI_ADDR_WIDTH'(idx_reg) << BURST_SHIFT);
                end
            end
            ST_BURST: begin
                if (aw_hs) begin
                    awvalid_next = 1'b0;
                    aw_done_next = 1'b1;
                end
                if (w_hs) begin
                    beat_cnt_next = beat_cnt_reg + 5'd1;
                end
                // Address and last data beat may complete in either order.
                if ((aw_done_reg | aw_hs) &&
                    ((beat_cnt_reg == 5'd16) || (w_hs && (beat_cnt_reg == 5'd15)))) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    state_next = ST_IDLE;
                    idx_next   = (idx_reg < cfg_data) ? idx_reg + ADDR_WIDTH'(1) : '0;
                    if (m_axi_bresp != 2'b00) begin
                        error_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg    <= ST_IDLE;
            awvalid_reg  <= 1'b0;
            aw_done_reg  <= 1'b0;
            beat_cnt_reg <= '0;
            idx_reg      <= '0;
            awaddr_reg   <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            awvalid_reg  <= awvalid_next;
            aw_done_reg  <= aw_done_next;
            beat_cnt_reg <= beat_cnt_next;
            idx_reg      <= idx_next;
            awaddr_reg   <= awaddr_next;
            error_reg    <= error_next;
        end
    end

endmodule

// File: tb/tb_axis_ram_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_axis_ram_burst_writer
//
// Directed bench: an AXIS source task, a configurable AXI3 slave model and a
// negedge monitor that records every AW/W/B handshake. Each scenario task
// drives stimulus and compares recorded traffic against hand-computed values.
// ---------------------------------------------------------------------------
module tb_axis_ram_burst_writer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] min_addr = '0;
    logic [15:0] cfg_data = '0;
    logic [15:0] sts_data;
    logic        sts_error;
    logic [5:0]  m_axi_awid;
    logic [3:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [5:0]  m_axi_wid;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [5:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;

    axis_ram_burst_writer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .min_addr      (min_addr),
        .cfg_data      (cfg_data),
        .sts_data      (sts_data),
        .sts_error     (sts_error),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wid     (m_axi_wid),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready)
    );

    initial begin
        forever #5 aclk = ~aclk;
    end

    // Bookkeeping
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] w_q[$];
    bit          wl_q[$];
    logic [31:0] aw_q[$];
    logic [15:0] sts_q[$];
    bit          err_q[$];
    int          n_aw = 0, n_wlast = 0, n_b = 0, b_issued = 0, viol = 0;
    bit          b_pend = 0;
    logic [31:0] seq = 32'h0000_0100;

    // Slave knobs
    int aw_delay = 0, b_delay = 0, err_at = -1;
    bit aw_hold = 0, w_hold = 0, w_rand = 0;
    int aw_wait = 0, b_wait = 0;

    // Monitor: handshakes seen at a negedge complete at the following posedge.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (b_pend) begin
                    sts_q.push_back(sts_data);
                    err_q.push_back(sts_error);
                    $display("B #%0d done: sts_data=%0d sts_error=%0b", sts_q.size(), sts_data, sts_error);
                    b_pend = 0;
                end
                if (m_axi_awvalid && m_axi_awready) begin
                    if (n_aw != n_b) viol++;
                    aw_q.push_back(m_axi_awaddr);
                    n_aw++;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    w_q.push_back(m_axi_wdata);
                    wl_q.push_back(m_axi_wlast);
                    if (m_axi_wlast) n_wlast++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    n_b++;
                    b_pend = 1;
                end
            end
        end
    end

    // AXI slave model, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                m_axi_awready = 0;
                m_axi_wready  = 0;
                m_axi_bvalid  = 0;
                m_axi_bresp   = 2'b00;
                aw_wait = 0;
                b_wait  = 0;
            end else begin
                if (m_axi_awready) begin
                    m_axi_awready = 0;
                    aw_wait = 0;
                end else if (m_axi_awvalid && !aw_hold) begin
                    if (aw_wait >= aw_delay) m_axi_awready = 1;
                    else aw_wait++;
                end
                if (w_hold) m_axi_wready = 0;
                else if (w_rand) m_axi_wready = 1'($urandom_range(0, 1));
                else m_axi_wready = 1;
                if (m_axi_bvalid) begin
                    if (n_b == b_issued) m_axi_bvalid = 0;
                end else if (((n_aw < n_wlast) ? n_aw : n_wlast) > b_issued) begin
                    if (b_wait >= b_delay) begin
                        m_axi_bvalid = 1;
                        m_axi_bresp  = (b_issued == err_at) ? 2'b10 : 2'b00;
                        b_issued++;
                        b_wait = 0;
                    end else begin
                        b_wait++;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_tb();
        exp_q.delete(); w_q.delete(); wl_q.delete();
        aw_q.delete(); sts_q.delete(); err_q.delete();
        n_aw = 0; n_wlast = 0; n_b = 0; b_issued = 0; viol = 0; b_pend = 0;
    endtask

    task automatic apply_reset();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        #5;
        clear_tb();
        aresetn = 1;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic push_words(input int n);
        int waited;
        bit done;
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = {~seq, seq};
            s_axis_tdata  = d;
            s_axis_tvalid = 1;
            done   = 0;
            waited = 0;
            while (!done) begin
                @(negedge aclk);
                if (s_axis_tready) done = 1;
                else waited++;
                @(posedge aclk);
                #1;
                if (!done && waited > 3000) begin
                    n_checks++;
                    $display("FAIL push_timeout: word %0d not accepted after %0d cycles, expected acceptance", i, waited);
                    s_axis_tvalid = 0;
                    return;
                end
            end
            exp_q.push_back(d);
            seq++;
        end
        s_axis_tvalid = 0;
    endtask

    task automatic wait_b(input int target, input int budget, output bit ok);
        int c;
        c = 0;
        while (sts_q.size() < target && c < budget) begin
            @(posedge aclk);
            #1;
            c++;
        end
        ok = (sts_q.size() >= target);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        aresetn = 0;
        repeat (4) @(posedge aclk);
        #1;
        n_checks++; if (m_axi_awvalid !== 1'b0) $display("FAIL reset_awvalid: got %b expected 0", m_axi_awvalid); else n_pass++;
        n_checks++; if (m_axi_wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b expected 0", m_axi_wvalid); else n_pass++;
        n_checks++; if (m_axi_bready !== 1'b0) $display("FAIL reset_bready: got %b expected 0", m_axi_bready); else n_pass++;
        n_checks++; if (sts_data !== 16'd0) $display("FAIL reset_sts_data: got %0d expected 0", sts_data); else n_pass++;
        n_checks++; if (sts_error !== 1'b0) $display("FAIL reset_sts_error: got %b expected 0", sts_error); else n_pass++;
        n_checks++; if (s_axis_tready !== 1'b0) $display("FAIL reset_tready_low: got %b expected 0", s_axis_tready); else n_pass++;
        clear_tb();
        aresetn = 1;
        repeat (2) @(posedge aclk);
        #1;
        n_checks++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready_high: got %b expected 1", s_axis_tready); else n_pass++;
    endtask

    task automatic test_single_burst();
        bit ok;
        int early, mism, lmism;
        min_addr = 32'h1E00_0000;
        cfg_data = 16'd3;
        aw_delay = 0; b_delay = 0; w_rand = 0; aw_hold = 0; w_hold = 0; err_at = -1;
        n_checks++;
        if ({m_axi_awid, m_axi_wid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb} !==
            {6'd0, 6'd0, 4'd15, 3'd3, 2'b01, 4'b0110, 8'hFF})
            $display("FAIL const_fields: got awid=%0d wid=%0d awlen=%0d awsize=%0d awburst=%b awcache=%b wstrb=%h expected 0,0,15,3,01,0110,ff",
                     m_axi_awid, m_axi_wid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb);
        else n_pass++;
        push_words(15);
        early = 0;
        repeat (10) begin
            @(posedge aclk);
            #1;
            if (m_axi_awvalid) early++;
        end
        n_checks++; if (early != 0 || n_aw != 0) $display("FAIL single_no_aw_15: awvalid seen %0d cycles, %0d AW, expected 0", early, n_aw); else n_pass++;
        push_words(1);
        n_checks++; if (m_axi_awvalid !== 1'b0) $display("FAIL single_aw_not_early: got awvalid=%b expected 0 in push cycle", m_axi_awvalid); else n_pass++;
        wait_b(1, 200, ok);
        n_checks++; if (!ok) $display("FAIL single_b_timeout: got %0d responses expected 1", sts_q.size()); else n_pass++;
        n_checks++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h1E00_0000)
            $display("FAIL single_awaddr: got %0d AW first=%h expected 1 AW at 1e000000", aw_q.size(), (aw_q.size() > 0) ? aw_q[0] : 32'hx);
        else n_pass++;
        mism = 0; lmism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= w_q.size() || w_q[i] !== exp_q[i]) mism++;
            if (i < wl_q.size() && wl_q[i] != (i == 15)) lmism++;
        end
        n_checks++; if (mism != 0 || w_q.size() != 16) $display("FAIL single_wdata: got %0d beats, %0d wrong, expected 16 in order", w_q.size(), mism); else n_pass++;
        n_checks++; if (lmism != 0) $display("FAIL single_wlast: got %0d misplaced wlast expected 0", lmism); else n_pass++;
        n_checks++; if (sts_data !== 16'd1) $display("FAIL single_sts_data: got %0d expected 1", sts_data); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int mism;
        logic [31:0] exp_addr [4] = '{32'h1E00_0000, 32'h1E00_0080, 32'h1E00_0100, 32'h1E00_0000};
        logic [15:0] exp_sts  [4] = '{16'd1, 16'd2, 16'd0, 16'd1};
        apply_reset();
        cfg_data = 16'd2;
        push_words(64);
        wait_b(4, 400, ok);
        n_checks++; if (!ok) $display("FAIL wrap_b_timeout: got %0d responses expected 4", sts_q.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (k >= aw_q.size() || aw_q[k] !== exp_addr[k])
                $display("FAIL wrap_awaddr%0d: got %h expected %h", k, (k < aw_q.size()) ? aw_q[k] : 32'hx, exp_addr[k]);
            else n_pass++;
            n_checks++;
            if (k >= sts_q.size() || sts_q[k] !== exp_sts[k])
                $display("FAIL wrap_sts%0d: got %0d expected %0d", k, (k < sts_q.size()) ? sts_q[k] : 16'hx, exp_sts[k]);
            else n_pass++;
        end
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= w_q.size() || w_q[i] !== exp_q[i]) mism++;
        n_checks++; if (mism != 0 || w_q.size() != 64) $display("FAIL wrap_wdata: got %0d beats, %0d wrong, expected 64 in order", w_q.size(), mism); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int mism, lmism;
        logic [31:0] exp_addr [3] = '{32'hFFFF_FF80, 32'h0000_0000, 32'h0000_0080};
        apply_reset();
        min_addr = 32'hFFFF_FF80;
        cfg_data = 16'd7;
        aw_delay = 10; b_delay = 5; w_rand = 1;
        push_words(48);
        wait_b(3, 3000, ok);
        n_checks++; if (!ok) $display("FAIL bp_b_timeout: got %0d responses expected 3", sts_q.size()); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= aw_q.size() || aw_q[k] !== exp_addr[k])
                $display("FAIL bp_awaddr%0d: got %h expected %h", k, (k < aw_q.size()) ? aw_q[k] : 32'hx, exp_addr[k]);
            else n_pass++;
        end
        mism = 0; lmism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= w_q.size() || w_q[i] !== exp_q[i]) mism++;
            if (i < wl_q.size() && wl_q[i] != ((i % 16) == 15)) lmism++;
        end
        n_checks++; if (mism != 0 || w_q.size() != 48) $display("FAIL bp_wdata: got %0d beats, %0d wrong, expected 48 in order", w_q.size(), mism); else n_pass++;
        n_checks++; if (lmism != 0) $display("FAIL bp_wlast: got %0d misplaced wlast expected 0", lmism); else n_pass++;
        n_checks++; if (viol != 0 || aw_q.size() != 3) $display("FAIL bp_one_outstanding: got %0d early AW, %0d AW total, expected 0 and 3", viol, aw_q.size()); else n_pass++;
        w_rand = 0; aw_delay = 0; b_delay = 0;
    endtask

    task automatic test_full();
        bit ok;
        int mism, leak;
        apply_reset();
        min_addr = 32'h1000_0000;
        cfg_data = 16'd31;
        aw_hold = 1; w_hold = 1;
        push_words(512);
        // Source keeps offering one more word while the FIFO is full.
        s_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        s_axis_tvalid = 1;
        leak = 0;
        repeat (8) begin
            @(negedge aclk);
            if (s_axis_tready !== 1'b0) leak++;
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 0;
        n_checks++; if (leak != 0) $display("FAIL full_tready: got tready high %0d cycles expected 0", leak); else n_pass++;
        n_checks++; if (n_aw != 0 || w_q.size() != 0) $display("FAIL full_stalled: got %0d AW %0d W expected 0 and 0", n_aw, w_q.size()); else n_pass++;
        aw_hold = 0; w_hold = 0;
        wait_b(32, 5000, ok);
        n_checks++; if (!ok) $display("FAIL full_b_timeout: got %0d responses expected 32", sts_q.size()); else n_pass++;
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= w_q.size() || w_q[i] !== exp_q[i]) mism++;
        n_checks++; if (mism != 0 || w_q.size() != 512) $display("FAIL full_wdata: got %0d beats, %0d wrong, expected 512 in order", w_q.size(), mism); else n_pass++;
        n_checks++;
        if (aw_q.size() != 32 || aw_q[31] !== 32'h1000_0F80)
            $display("FAIL full_last_awaddr: got %0d AW last=%h expected 32 AW last 10000f80", aw_q.size(), (aw_q.size() > 0) ? aw_q[aw_q.size()-1] : 32'hx);
        else n_pass++;
        n_checks++; if (sts_data !== 16'd0) $display("FAIL full_sts_wrap: got %0d expected 0", sts_data); else n_pass++;
    endtask

    task automatic test_error_and_reset();
        bit ok;
        int c, mism;
        apply_reset();
        min_addr = 32'h1E00_0000;
        cfg_data = 16'd3;
        err_at = 1;
        push_words(32);
        wait_b(2, 400, ok);
        n_checks++; if (!ok || err_q[0] !== 1'b0 || err_q[1] !== 1'b1)
            $display("FAIL err_set: got %0d responses, error after B0/B1 = %b/%b expected 0/1", sts_q.size(),
                     (err_q.size() > 0) ? err_q[0] : 1'bx, (err_q.size() > 1) ? err_q[1] : 1'bx);
        else n_pass++;
        push_words(16);
        wait_b(3, 400, ok);
        n_checks++; if (!ok || sts_error !== 1'b1) $display("FAIL err_sticky: got sts_error=%b expected 1", sts_error); else n_pass++;
        n_checks++; if (sts_data !== 16'd3) $display("FAIL err_sts_data: got %0d expected 3", sts_data); else n_pass++;
        // Start a fourth burst and reset partway through its data beats.
        w_rand = 1;
        push_words(16);
        c = 0;
        while (w_q.size() < 52 && c < 500) begin
            @(posedge aclk);
            #1;
            c++;
        end
        n_checks++; if (w_q.size() < 52) $display("FAIL mid_burst_reach: got %0d beats expected at least 52", w_q.size()); else n_pass++;
        aresetn = 0;
        @(posedge aclk);
        #1;
        n_checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b000)
            $display("FAIL rst_mid_valids: got aw/w/b=%b%b%b expected 000", m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        else n_pass++;
        n_checks++; if (sts_data !== 16'd0) $display("FAIL rst_mid_sts_data: got %0d expected 0", sts_data); else n_pass++;
        n_checks++; if (sts_error !== 1'b0) $display("FAIL rst_mid_sts_error: got %b expected 0", sts_error); else n_pass++;
        #4;
        clear_tb();
        err_at = -1;
        w_rand = 0;
        aresetn = 1;
        repeat (20) @(posedge aclk);
        #1;
        n_checks++;
        if (n_aw != 0 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || s_axis_tready !== 1'b1)
            $display("FAIL rst_fifo_flushed: got %0d AW awvalid=%b wvalid=%b tready=%b expected 0,0,0,1",
                     n_aw, m_axi_awvalid, m_axi_wvalid, s_axis_tready);
        else n_pass++;
        push_words(16);
        wait_b(1, 200, ok);
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= w_q.size() || w_q[i] !== exp_q[i]) mism++;
        n_checks++; if (!ok || mism != 0 || w_q.size() != 16) $display("FAIL rst_fresh_data: got %0d beats, %0d wrong, expected 16 fresh words", w_q.size(), mism); else n_pass++;
        n_checks++;
        if (aw_q.size() != 1 || aw_q[0] !== 32'h1E00_0000 || err_q.size() != 1 || err_q[0] !== 1'b0)
            $display("FAIL rst_fresh_burst: got %0d AW addr=%h err=%b expected 1 AW at 1e000000 err 0",
                     aw_q.size(), (aw_q.size() > 0) ? aw_q[0] : 32'hx, (err_q.size() > 0) ? err_q[0] : 1'bx);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_wrap();
        test_backpressure();
        test_full();
        test_error_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
